// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, holding the front end via STALL meanwhile.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic            FLUSH,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] OP_A,
  input  logic [XLEN-1:0] OP_B,
  input  logic [4:0]      RD_IN,
  output logic [XLEN-1:0] RESULT,
  output logic [4:0]      RD_OUT,
  output logic            DONE,
  output logic            STALL
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  function automatic logic [XLEN-1:0] sign_fix(input logic [XLEN-1:0] v, input logic neg);
    logic signed [XLEN-1:0] sv;
    sv = v;
    return neg ? -sv : sv;
  endfunction

  function automatic logic [2*XLEN-1:0] sign_fix_wide(input logic [2*XLEN-1:0] v, input logic neg);
    logic signed [2*XLEN-1:0] sv;
    sv = v;
    return neg ? -sv : sv;
  endfunction

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN:0]   acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        funct_q, funct_d;
  logic              neg_q, neg_d;
  logic              nega_q, nega_d;
  logic [4:0]        rd_tag_q, rd_tag_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  logic              is_div, a_signed, b_signed, sign_a, sign_b;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   mag_a, mag_b, special_val;
  logic [XLEN:0]     mul_sum, div_diff;
  logic [2*XLEN:0]   div_sh, acc_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fin_val;

  // Accept-time decode: operand magnitudes, result signs and preloaded special results
  always_comb begin
    is_div   = FUNCT3[2];
    a_signed = (FUNCT3 == 3'b001) || (FUNCT3 == 3'b010) ||
               (FUNCT3 == 3'b100) || (FUNCT3 == 3'b110);
    b_signed = (FUNCT3 == 3'b001) || (FUNCT3 == 3'b100) || (FUNCT3 == 3'b110);
    sign_a   = a_signed & OP_A[XLEN-1];
    sign_b   = b_signed & OP_B[XLEN-1];
    mag_a    = sign_fix(OP_A, sign_a);
    mag_b    = sign_fix(OP_B, sign_b);
    div_zero = is_div && (OP_B == '0);
    div_ovf  = is_div && !FUNCT3[0] && (OP_A == {1'b1, {(XLEN-1){1'b0}}}) && (OP_B == '1);
    if (div_zero) special_val = FUNCT3[1] ? OP_A : '1;
    else          special_val = FUNCT3[1] ? '0 : OP_A;
  end

  // One radix-2 step: multiply adds into the high half and shifts right;
  // divide shifts left and keeps the trial subtraction when it does not borrow.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {acc_q[2*XLEN-1:0], 1'b0};
    div_diff = div_sh[2*XLEN:XLEN] - {1'b0, opnd_q};
    if (funct_q[2]) acc_step = div_diff[XLEN] ? div_sh : {div_diff, div_sh[XLEN-1:1], 1'b1};
    else            acc_step = {1'b0, mul_sum, acc_q[XLEN-1:1]};
  end

  // Finalise: sign-correct the last step's product/quotient/remainder and select
  always_comb begin
    prod_fix = sign_fix_wide(acc_step[2*XLEN-1:0], neg_q);
    quot_fix = sign_fix(acc_step[XLEN-1:0], neg_q);
    rem_fix  = sign_fix(acc_step[2*XLEN-1:XLEN], nega_q);
    case (funct_q)
      3'b000:                 fin_val = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_val = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_val = quot_fix;
      default:                fin_val = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    funct_d  = funct_q;
    neg_d    = neg_q;
    nega_d   = nega_q;
    rd_tag_d = rd_tag_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    if (FLUSH) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            funct_d  = FUNCT3;
            rd_tag_d = RD_IN;
            cnt_d    = '0;
            neg_d    = sign_a ^ sign_b;
            nega_d   = sign_a;
            acc_d    = {{(XLEN+1){1'b0}}, (is_div ? mag_a : mag_b)};
            opnd_d   = is_div ? mag_b : mag_a;
            if (div_zero || div_ovf) begin
              result_d = special_val;
              rd_out_d = RD_IN;
              state_d  = FIN;
            end else begin
              state_d  = CALC;
            end
          end
        end
        CALC: begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) begin
            result_d = fin_val;
            rd_out_d = rd_tag_q;
            state_d  = FIN;
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      funct_q  <= '0;
      neg_q    <= 1'b0;
      nega_q   <= 1'b0;
      rd_tag_q <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      funct_q  <= funct_d;
      neg_q    <= neg_d;
      nega_q   <= nega_d;
      rd_tag_q <= rd_tag_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign RESULT = result_q;
  assign RD_OUT = rd_out_q;
  assign DONE   = (state_q == FIN);
  assign STALL  = ((state_q == IDLE) && START && !FLUSH) || (state_q == CALC);

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle RV32M multiply/divide unit in the EX stage.
- Consumes operands, funct3 and destination register from the ID/EX pipeline register.
- Holds the front of the pipeline via STALL while an M-extension op iterates.
- Returns a registered RESULT with a one-cycle DONE pulse to the EX result mux.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous, active-low reset
START  input  1  ID/EX holds a valid M-extension op
FLUSH  input  1  synchronous abort (branch taken / pipeline flush)
FUNCT3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
OP_A  input  XLEN  rs1 value (dividend / multiplicand)
OP_B  input  XLEN  rs2 value (divisor / multiplier)
RD_IN  input  5  destination register of the op
RESULT  output  XLEN  registered result
RD_OUT  output  5  destination tag captured at accept
DONE  output  1  one-cycle pulse, RESULT/RD_OUT valid
STALL  output  1  freeze PC, IF/ID and ID/EX

Behaviour:
- Reset: RESET sampled low at a rising edge gives state=IDLE, RESULT=0, RD_OUT=0, DONE=0, counter=0, internal accumulators=0.
- Reset priority: RESET > FLUSH > everything else; reset mid-operation aborts with no DONE.
- States: IDLE, CALC, FIN.
- IDLE:
  - START=1 at an edge accepts the op.
  - Captures FUNCT3 and RD_IN, the operand magnitudes, and the result sign. Signedness: DIV/REM/MULH both signed; MULHSU only OP_A signed; others unsigned.
  - Counter is cleared to 0.
  - Normal ops go to CALC.
  - Special cases go directly to FIN with the result preloaded:
    - divide by zero: DIV/DIVU give all-ones; REM/REMU give OP_A.
    - signed overflow (OP_A=0x80000000, OP_B=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC:
  - One radix-2 iteration per cycle. Multiply is shift-add into a 2*XLEN product. Divide is restoring shift-subtract, giving quotient and remainder.
  - Counter increments each cycle.
  - After iteration XLEN (counter==XLEN-1 at the edge): finalise and go to FIN.
  - Finalise: apply two's-complement sign fix. Select the low word (MUL), the high word (MULH*), the quotient (DIV*) or the remainder (REM*). The remainder takes the sign of the dividend. Register the selection into RESULT.
- FIN: DONE=1, STALL=0 for exactly one cycle; next edge returns to IDLE. START is ignored in FIN, because the completing instruction leaves ID/EX at this edge.
- STALL (combinational): (state==IDLE && START && !FLUSH) || state==CALC.
- Latency:
  - Normal op: accepted at edge T0; DONE high in the cycle after edge T0+XLEN; STALL high XLEN+1 cycles.
  - Special case: DONE in the cycle after T0; STALL high 1 cycle.
- FLUSH=1 at any edge: return to IDLE, DONE=0 next cycle, RESULT keeps its previous value. START and FLUSH both high in IDLE means the op is not accepted.
- DONE is low in every state except FIN. RESULT and RD_OUT change only at the finalise edge or on reset.
- Operand inputs may change after acceptance without affecting the result.

Test Plan:
- Reset: RESET=0 for 2 edges mid-CALC -> RESULT=0, DONE=0, STALL=0, state IDLE; no DONE afterwards.
- MUL: OP_A=7, OP_B=-3 (0xFFFFFFFD), FUNCT3=000 -> STALL 33 cycles; DONE 32 cycles after accept edge, RESULT=0xFFFFFFEB. MULH on the same operands -> 0xFFFFFFFF. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- Signed divide: DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU -> 2. RD_OUT equals RD_IN captured at accept.
- Special cases: DIV x/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, REM -> 0. Each gives DONE in the cycle after accept and 1 stall cycle.
- FLUSH at CALC iteration 10 -> next cycle IDLE, STALL=0, no DONE, RESULT unchanged. FLUSH with START in IDLE -> no accept.
- Back-to-back: new START present in FIN -> ignored; accepted at the following IDLE edge; second result correct and independent of the first.
